pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Single pipeline stage register with optional two-entry skid buffer.
// out_valid/out_data come straight from flops; bubbles present all-zero data.
module pipe_stage_reg #(
    parameter int WIDTH   = 71,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_outValid;
    logic             r_inReady;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_accept;
    logic             w_pop;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = r_outValid && out_ready && !flush;

    // Skid mode breaks the out_ready->in_ready path with a registered ready.
    assign in_ready  = SKID_EN ? r_inReady : (!r_outValid || out_ready);
    assign out_valid = r_outValid;
    assign out_data  = r_main;
    assign count     = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_inReady <= 1'b1;
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main     <= in_data;
                        r_outValid <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end else if (w_pop) begin
                        r_main     <= '0;
                        r_outValid <= 1'b0;
                        r_state    <= EMPTY;
                    end else if (w_accept && SKID_EN) begin
                        r_skid    <= in_data;
                        r_inReady <= 1'b0;
                        r_state   <= TWO;
                    end
                end
                TWO: begin
                    // Skid slides into main on the same edge the main entry leaves.
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_state <= ONE;
                    end else begin
                        r_inReady <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_outValid <= 1'b0;
                    r_main     <= '0;
                    r_skid     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard bench for pipe_stage_reg in both skid and plain modes.
module tb_pipe_stage_reg;

    localparam int W = 71;

    logic         clk = 1'b0;
    logic         reset;

    logic         flush, inValid, outReady;
    logic [W-1:0] inData;
    logic         inReady, outValid;
    logic [W-1:0] outData;
    logic [1:0]   count;

    logic         flush0, inValid0, outReady0;
    logic [W-1:0] inData0;
    logic         inReady0, outValid0;
    logic [W-1:0] outData0;
    logic [1:0]   count0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .count(count)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(inValid0), .in_ready(inReady0), .in_data(inData0),
        .out_valid(outValid0), .out_ready(outReady0), .out_data(outData0),
        .count(count0)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        logic       eValid;
        logic [7:0] eData;
        logic [1:0] eCount;
        logic       eReady;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic applyStimulus(input logic fl, input logic iv, input logic ordy, input logic [7:0] d);
        flush    = fl;
        inValid  = iv;
        outReady = ordy;
        inData   = W'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string name, input logic v, input logic [7:0] d,
                              input logic [1:0] c, input logic r);
        checkOutput({name, ".valid"}, W'(outValid), W'(v));
        checkOutput({name, ".data"},  outData,      W'(d));
        checkOutput({name, ".count"}, W'(count),    W'(c));
        checkOutput({name, ".ready"}, W'(inReady),  W'(r));
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] curPay;
        logic [W-1:0] expData;
        logic         popNow, accNow;
        int           sent;
        bit           done;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 8'hA1, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 8'hA2, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hB1, 1'b1, 8'hB1, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 8'hB1, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hB3, 1'b1, 8'hB1, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'hB3, 1'b1, 8'hB2, 2'd1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hB3, 1'b1, 8'hB3, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'hC1, 1'b1, 8'hB3, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'hD1, 1'b1, 8'hD1, 2'd1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 2'd0, 1'b1};

        reset     = 1'b0;
        flush     = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b0;
        inData    = '0;
        flush0    = 1'b0;
        inValid0  = 1'b0;
        outReady0 = 1'b0;
        inData0   = '0;

        // Held in reset across edges: everything empty, ready differs by mode.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkState("reset", 1'b0, 8'h00, 2'd0, 1'b0);
        checkOutput("reset.ready0", W'(inReady0), W'(1'b1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("release.readyBeforeEdge", W'(inReady), W'(1'b0));
        @(posedge clk);
        #1;
        checkOutput("release.readyAfterEdge", W'(inReady), W'(1'b1));

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].d);
            checkState($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eData,
                       vecs[i].eCount, vecs[i].eReady);
        end

        // Backpressure: third payload must wait upstream until skid drains.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0A);
        checkState("bp.acceptA", 1'b1, 8'h0A, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0B);
        checkState("bp.acceptB", 1'b1, 8'h0A, 2'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h0C);
        checkState("bp.holdC", 1'b1, 8'h0A, 2'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h0C);
        checkState("bp.popA", 1'b1, 8'h0B, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h0C);
        checkState("bp.popB", 1'b1, 8'h0C, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkState("bp.popC", 1'b0, 8'h00, 2'd0, 1'b1);

        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'(k));
            checkState($sformatf("stream%0d", k), 1'b1, 8'(k), 2'd1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkState("stream.drain", 1'b0, 8'h00, 2'd0, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hF1);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            checkState($sformatf("stall%0d", s), 1'b1, 8'hF1, 2'd1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkState("stall.pop", 1'b0, 8'h00, 2'd0, 1'b1);

        // Asynchronous reset between edges while one entry is held.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hE1);
        checkState("areset.loaded", 1'b1, 8'hE1, 2'd1, 1'b1);
        inValid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkState("areset.during", 1'b0, 8'h00, 2'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset.readyBeforeEdge", W'(inReady), W'(1'b0));
        @(posedge clk);
        #1;
        checkState("areset.after", 1'b0, 8'h00, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hE2);
        checkState("areset.fresh", 1'b1, 8'hE2, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkState("areset.freshPop", 1'b0, 8'h00, 2'd0, 1'b1);

        // Plain-register instance: random handshakes against a FIFO scoreboard.
        sent   = 0;
        done   = 1'b0;
        curPay = W'({$urandom, $urandom, $urandom});
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            inValid0  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            inData0   = curPay;
            outReady0 = 1'($urandom_range(0, 1));
            #1;
            checkOutput("plain.valid", W'(outValid0), W'(q.size() != 0));
            checkOutput("plain.ready", W'(inReady0), W'((q.size() == 0) || outReady0));
            checkOutput("plain.count", W'(count0), W'(q.size()));
            if (!outValid0)
                checkOutput("plain.bubbleData", outData0, '0);
            popNow = outValid0 && outReady0;
            accNow = inValid0 && inReady0;
            if (popNow) begin
                expData = (q.size() != 0) ? q.pop_front() : '0;
                checkOutput("plain.order", outData0, expData);
            end
            if (accNow) begin
                q.push_back(curPay);
                sent++;
                curPay = W'({$urandom, $urandom, $urandom});
            end
            @(posedge clk);
            #1;
            done = (sent == 1000) && (q.size() == 0);
        end
        checkOutput("plain.completed", W'(done), W'(1'b1));
        checkOutput("plain.sent", W'(sent), W'(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
